// File: rtl/scale_price_ctrl.sv
// Pricing transaction controller: waits for a stable tared weight, then multiplies
// net weight by the latched per-kg price on a shift-add multiplier and saturates.
module scale_price_ctrl #(
    parameter int W_WIDTH       = 16,
    parameter int N_PROD        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [W_WIDTH-1:0]                        weight_in,
    input  logic                                      weight_valid,
    input  logic                                      tare_req,
    input  logic [((N_PROD > 1) ? $clog2(N_PROD) : 1)-1:0] prod_sel,
    input  logic                                      cfg_we,
    input  logic [((N_PROD > 1) ? $clog2(N_PROD) : 1)-1:0] cfg_addr,
    input  logic [W_WIDTH-1:0]                        cfg_price,
    input  logic                                      start,
    input  logic                                      abort,
    output logic                                      busy,
    output logic                                      done,
    output logic [W_WIDTH-1:0]                        total_price,
    output logic [W_WIDTH-1:0]                        net_weight,
    output logic                                      overflow,
    output logic                                      err_neg
);

    // state       | meaning
    // IDLE        | waiting for start; tare capture allowed
    // WAIT_STABLE | counting consecutive equal valid samples
    // MUL         | one shift-add iteration per cycle
    // DONE        | results valid, done pulse asserted

    localparam int AW    = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam int N_TBL = 1 << AW;
    localparam int CW    = $clog2(STABLE_CYCLES + 1);
    localparam int MW    = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
    localparam logic [CW-1:0] STAB_TC = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_STABLE,
        MUL,
        DONE
    } state_t;

    state_t                   state;
    logic [W_WIDTH-1:0]       price_tbl [N_TBL];
    logic [W_WIDTH-1:0]       tare;
    logic [W_WIDTH-1:0]       price_r;
    logic [W_WIDTH-1:0]       last_w;
    logic [W_WIDTH-1:0]       net_r;
    logic [CW-1:0]            stab_cnt;
    logic [CW-1:0]            stab_next;
    logic [2*W_WIDTH-1:0]     mcand;
    logic [W_WIDTH-1:0]       mplier;
    logic [2*W_WIDTH-1:0]     acc;
    logic [2*W_WIDTH-1:0]     acc_next;
    logic [MW-1:0]            mul_cnt;
    logic [W_WIDTH-1:0]       net_diff;

    assign net_diff  = weight_in - tare;
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
    assign stab_next = ((stab_cnt != '0) && (weight_in == last_w)) ? (stab_cnt + 1'b1) : CW'(1);

    // Table is padded to a power of two so any address decodes to real storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TBL; i++) begin
                price_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            price_tbl[cfg_addr] <= cfg_price;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            total_price <= '0;
            net_weight  <= '0;
            overflow    <= 1'b0;
            err_neg     <= 1'b0;
            tare        <= '0;
            price_r     <= '0;
            last_w      <= '0;
            net_r       <= '0;
            stab_cnt    <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            mul_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tare_req && weight_valid) begin
                        tare <= weight_in;
                    end
                    if (start) begin
                        price_r     <= price_tbl[prod_sel];
                        total_price <= '0;
                        net_weight  <= '0;
                        overflow    <= 1'b0;
                        err_neg     <= 1'b0;
                        stab_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_STABLE;
                    end
                end
                WAIT_STABLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (weight_valid) begin
                        stab_cnt <= stab_next;
                        last_w   <= weight_in;
                        if (stab_next == STAB_TC) begin
                            if (weight_in < tare) begin
                                err_neg     <= 1'b1;
                                total_price <= '0;
                                net_weight  <= '0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else begin
                                net_r   <= net_diff;
                                mcand   <= {{W_WIDTH{1'b0}}, net_diff};
                                mplier  <= price_r;
                                acc     <= '0;
                                mul_cnt <= MW'(W_WIDTH - 1);
                                state   <= MUL;
                            end
                        end
                    end
                end
                MUL: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc     <= acc_next;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        mul_cnt <= mul_cnt - 1'b1;
                        if (mul_cnt == '0) begin
                            net_weight <= net_r;
                            if (acc_next[2*W_WIDTH-1:W_WIDTH] != '0) begin
                                total_price <= '1;
                                overflow    <= 1'b1;
                            end else begin
                                total_price <= acc_next[W_WIDTH-1:0];
                            end
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scale_price_ctrl.sv
// Randomized bench for scale_price_ctrl; expected results come from a
// sample-sequence model (run-length stability, plain multiply, saturation).
module tb_scale_price_ctrl;

    localparam int W  = 16;
    localparam int NP = 8;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  weight_in;
    logic          weight_valid;
    logic          tare_req;
    logic [2:0]    prod_sel;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [W-1:0]  cfg_price;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [W-1:0]  total_price;
    logic [W-1:0]  net_weight;
    logic          overflow;
    logic          err_neg;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [W-1:0] tbl_m [NP];
    logic [W-1:0] tare_m;
    logic [W-1:0] samp_w [$];
    bit           samp_v [$];

    scale_price_ctrl #(.W_WIDTH(W), .N_PROD(NP), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .weight_in(weight_in), .weight_valid(weight_valid),
        .tare_req(tare_req), .prod_sel(prod_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_price(cfg_price), .start(start), .abort(abort), .busy(busy), .done(done),
        .total_price(total_price), .net_weight(net_weight), .overflow(overflow),
        .err_neg(err_neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [W-1:0] v);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_price = v;
        tick;
        cfg_we = 1'b0;
        tbl_m[a] = v;
    endtask

    task automatic tare_set(input logic [W-1:0] w);
        tare_req = 1'b1; weight_valid = 1'b1; weight_in = w;
        tick;
        tare_req = 1'b0; weight_valid = 1'b0;
        tare_m = w;
    endtask

    task automatic fill_const(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            samp_w.push_back(w);
            samp_v.push_back(1'b1);
        end
    endtask

    // Cycle c of a transaction is the one observed just after edge t+c, where
    // edge t accepted start; the datasheet calls that cycle t+c+1.
    task automatic run_txn(input string tag, input int sel, input bit do_tare,
                           input logic [W-1:0] tare_w, input int wr_cyc,
                           input int wr_addr, input logic [W-1:0] wr_val, input bit extra);
        logic [W-1:0] price_m, prev, acc_w, net_m;
        int           run, e, n_exp, got_n, pulses;
        bit           found, err_m, ovf_m;
        longint       prod, tot_m;
        logic [W-1:0] g_tot, g_net;
        logic         g_ovf, g_err;

        price_m = tbl_m[sel];
        if (do_tare) tare_m = tare_w;
        run = 0; found = 0; e = 0; prev = '0; acc_w = '0;
        for (int j = 0; j < samp_w.size(); j++) begin
            if (samp_v[j]) begin
                run  = (run > 0 && samp_w[j] == prev) ? run + 1 : 1;
                prev = samp_w[j];
                if (run == S && !found) begin
                    found = 1; e = j + 1; acc_w = samp_w[j];
                end
            end
        end
        err_m = (acc_w < tare_m);
        net_m = err_m ? '0 : acc_w - tare_m;
        prod  = longint'(net_m) * longint'(price_m);
        ovf_m = !err_m && (prod > 64'hFFFF);
        tot_m = err_m ? 0 : (ovf_m ? 64'hFFFF : prod);
        n_exp = err_m ? e : e + W;

        prod_sel = 3'(sel); start = 1'b1;
        if (do_tare) begin
            tare_req = 1'b1; weight_valid = 1'b1; weight_in = tare_w;
        end else begin
            weight_valid = 1'b0;
        end
        tick;
        start = 1'b0; tare_req = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        got_n = -1; pulses = 0;
        g_tot = '0; g_net = '0; g_ovf = 1'b0; g_err = 1'b0;
        for (int c = 1; c <= n_exp + 4; c++) begin
            if (c - 1 < samp_w.size()) begin
                weight_in = samp_w[c-1]; weight_valid = samp_v[c-1];
            end else begin
                weight_valid = 1'b0;
            end
            cfg_we = (c == wr_cyc);
            if (c == wr_cyc) begin
                cfg_addr = 3'(wr_addr); cfg_price = wr_val; tbl_m[wr_addr] = wr_val;
            end
            start    = extra && (c == 3);
            tare_req = extra && (c == 2);
            tick;
            if (done) begin
                pulses++;
                if (got_n < 0) begin
                    got_n = c; g_tot = total_price; g_net = net_weight;
                    g_ovf = overflow; g_err = err_neg;
                end
            end
        end
        cfg_we = 1'b0; start = 1'b0; tare_req = 1'b0; weight_valid = 1'b0;
        chk({tag, "_done_cycle"}, got_n, n_exp);
        chk({tag, "_done_pulses"}, pulses, 1);
        chk({tag, "_total"}, g_tot, tot_m);
        chk({tag, "_overflow"}, g_ovf, ovf_m);
        chk({tag, "_err_neg"}, g_err, err_m);
        if (!err_m) chk({tag, "_net"}, g_net, net_m);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_hold_total"}, total_price, tot_m);
        samp_w.delete();
        samp_v.delete();
    endtask

    initial begin
        int pulses;
        logic [W-1:0] base;
        rst_n = 1'b0; weight_in = '0; weight_valid = 1'b0; tare_req = 1'b0;
        prod_sel = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_price = '0;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < NP; i++) tbl_m[i] = '0;
        tare_m = '0;
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_total", total_price, 0);
        chk("rst_net", net_weight, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_neg, 0);
        rst_n = 1'b1;
        tick;

        cfg_write(0, 20);
        fill_const(500, S);
        run_txn("basic", 0, 0, 0, -1, 0, 0, 0);

        cfg_write(3, 100);
        fill_const(1000, S);
        run_txn("ovf", 3, 0, 0, -1, 0, 0, 0);

        tare_set(120);
        fill_const(620, S);
        run_txn("tared", 0, 0, 0, -1, 0, 0, 0);

        tare_set(300);
        fill_const(200, S);
        run_txn("neg", 0, 0, 0, -1, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            samp_w.push_back((i % 2 == 0) ? 16'd500 : 16'd501);
            samp_v.push_back(1'b1);
        end
        fill_const(500, S);
        run_txn("alt_tare0", 0, 1, 0, -1, 0, 0, 0);

        fill_const(500, S);
        run_txn("cfg_in_mul", 0, 0, 0, 7, 0, 7, 0);

        // abort during MUL iteration 8 (edge t+12)
        fill_const(500, S);
        prod_sel = 3'd0; start = 1'b1;
        tick;
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c - 1 < samp_w.size()) begin
                weight_in = samp_w[c-1]; weight_valid = samp_v[c-1];
            end else begin
                weight_valid = 1'b0;
            end
            abort = (c == 12);
            tick;
            abort = 1'b0;
            if (c == 11) chk("abort_busy_before", busy, 1);
            if (c == 12) chk("abort_idle", busy, 0);
            if (done) pulses++;
        end
        samp_w.delete(); samp_v.delete();
        chk("abort_no_done", pulses, 0);
        chk("abort_total", total_price, 0);
        chk("abort_net", net_weight, 0);

        tare_set(500);
        fill_const(500, S);
        run_txn("zero_net", 3, 0, 0, -1, 0, 0, 0);
        tare_set(0);

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write($urandom_range(0, NP - 1),
                          ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300)));
            if ($urandom_range(0, 3) == 0) begin
                tare_req = 1'b1; weight_valid = 1'b0; weight_in = 16'($urandom);
                tick;
                tare_req = 1'b0;
            end
            base = 16'($urandom_range(0, 2000));
            for (int i = 0; i < $urandom_range(0, 8); i++) begin
                samp_w.push_back(($urandom_range(0, 1) == 1) ? base + 16'd1 : base);
                samp_v.push_back($urandom_range(0, 2) != 0);
            end
            fill_const(base, S);
            run_txn($sformatf("rnd%0d", k), $urandom_range(0, NP - 1),
                    $urandom_range(0, 3) == 0, 16'($urandom_range(0, 400)),
                    $urandom_range(1, 10), $urandom_range(0, NP - 1), 16'($urandom),
                    $urandom_range(0, 1) == 1);
        end

        // asynchronous reset while in MUL; table and tare must be lost
        tare_set(100);
        cfg_write(3, 100);
        fill_const(500, S);
        prod_sel = 3'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            weight_in = samp_w[(c - 1) % S]; weight_valid = 1'b1;
            tick;
        end
        weight_valid = 1'b0;
        samp_w.delete(); samp_v.delete();
        chk("pre_rst_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_total", total_price, 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < NP; i++) tbl_m[i] = '0;
        tare_m = '0;
        tick;
        fill_const(500, S);
        run_txn("post_rst", 3, 0, 0, -1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
